// File: rtl/regfile_pkg.sv
//------------------------------------------------------------------------------
// regfile_pkg : shared sizing constants for the 2-read/1-write register file.
// Revision    : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/10ps
`default_nettype none

package regfile_pkg;

   localparam int                NUM_REGS = 32;
   localparam int                DATA_W   = 64;
   localparam int                IDX_W    = 5;
   localparam logic [IDX_W-1:0]  ZR_IDX   = 5'd31;

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/decoder_5_32.sv
//------------------------------------------------------------------------------
// decoder_5_32 : one-hot write-enable decoder; the zero-register index never decodes.
// Revision     : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/10ps
`default_nettype none

module decoder_5_32
   import regfile_pkg::*;
(
   input  logic                i_en,
   input  logic [IDX_W-1:0]    i_idx,
   output logic [NUM_REGS-1:0] o_onehot
);

   always_comb begin
      o_onehot = '0;
      if (i_en && (i_idx != ZR_IDX)) begin
         o_onehot[i_idx] = 1'b1;
      end
   end

endmodule : decoder_5_32

`default_nettype wire

// File: rtl/regfile_2r1w.sv
//------------------------------------------------------------------------------
// regfile_2r1w : 31 x 64-bit register file with XZR, two bypassed read ports.
// Revision     : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/10ps
`default_nettype none

module regfile_2r1w
   import regfile_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              RegWrite,
   input  logic [IDX_W-1:0]  WriteRegister,
   input  logic [DATA_W-1:0] WriteData,
   input  logic [IDX_W-1:0]  ReadRegister1,
   input  logic [IDX_W-1:0]  ReadRegister2,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2
);

   logic                             w_wr_en;
   logic [NUM_REGS-1:0]              w_wr_onehot;
   logic [NUM_REGS-1:0][DATA_W-1:0]  w_rd_arr;

   assign w_wr_en = RegWrite & ~reset;

   decoder_5_32 u_dec (
      .i_en     (w_wr_en),
      .i_idx    (WriteRegister),
      .o_onehot (w_wr_onehot)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS - 1; gi++) begin : g_reg
         logic [DATA_W-1:0] r_q;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_q <= '0;
            end else if (w_wr_onehot[gi]) begin
               r_q <= WriteData;
            end
         end

         assign w_rd_arr[gi] = r_q;
      end
   endgenerate

   assign w_rd_arr[ZR_IDX] = '0;

   // The one-hot vector already folds in enable, reset and the XZR exclusion,
   // so a hit on the read index is exactly the bypass condition.
   assign ReadData1 = reset                      ? '0        :
                      w_wr_onehot[ReadRegister1] ? WriteData :
                                                   w_rd_arr[ReadRegister1];

   assign ReadData2 = reset                      ? '0        :
                      w_wr_onehot[ReadRegister2] ? WriteData :
                                                   w_rd_arr[ReadRegister2];

endmodule : regfile_2r1w

`default_nettype wire

// File: tb/tb_regfile_2r1w.sv
//------------------------------------------------------------------------------
// tb_regfile_2r1w : directed and randomized checks of regfile_2r1w against an array model.
// Revision        : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/10ps
`default_nettype none

module tb_regfile_2r1w;

   logic        clk = 1'b0;
   logic        reset;
   logic        RegWrite;
   logic [4:0]  WriteRegister;
   logic [63:0] WriteData;
   logic [4:0]  ReadRegister1;
   logic [4:0]  ReadRegister2;
   logic [63:0] ReadData1;
   logic [63:0] ReadData2;

   logic [63:0] model [32];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   regfile_2r1w dut (
      .clk           (clk),
      .reset         (reset),
      .RegWrite      (RegWrite),
      .WriteRegister (WriteRegister),
      .WriteData     (WriteData),
      .ReadRegister1 (ReadRegister1),
      .ReadRegister2 (ReadRegister2),
      .ReadData1     (ReadData1),
      .ReadData2     (ReadData2)
   );

   // Expected read value straight from the architectural rules.
   function automatic logic [63:0] ref_read(input logic [4:0] idx);
      if (reset)                               return 64'h0;
      if (idx == 5'd31)                        return 64'h0;
      if (RegWrite && WriteRegister == idx)    return WriteData;
      return model[idx];
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_ports(input string tag);
      check({tag, "_rd1"}, ReadData1, ref_read(ReadRegister1));
      check({tag, "_rd2"}, ReadData2, ref_read(ReadRegister2));
   endtask

   task automatic clear_model();
      for (int i = 0; i < 32; i++) model[i] = 64'h0;
   endtask

   // Advance one clock; the model commits the write seen at the edge.
   task automatic tick();
      @(posedge clk);
      if (!reset && RegWrite && WriteRegister != 5'd31) model[WriteRegister] = WriteData;
      #1;
   endtask

   task automatic drive(input logic we, input logic [4:0] wr, input logic [63:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2);
      RegWrite      = we;
      WriteRegister = wr;
      WriteData     = wd;
      ReadRegister1 = r1;
      ReadRegister2 = r2;
      #1;
   endtask

   initial begin
      clear_model();
      reset = 1'b1;
      drive(1'b1, 5'd5, 64'h5555, 5'd5, 5'd31);
      check("reset_rd1", ReadData1, 64'h0);
      check("reset_rd2", ReadData2, 64'h0);
      tick();
      drive(1'b1, 5'd5, 64'h5555, 5'd5, 5'd0);
      check_ports("reset_hold");
      #2 reset = 1'b0;
      tick();

      // Write X5 then assert reset mid-cycle: storage clears before any edge.
      drive(1'b1, 5'd5, 64'hDEAD_BEEF, 5'd0, 5'd1);
      tick();
      drive(1'b0, 5'd0, 64'h0, 5'd5, 5'd5);
      check("x5_written", ReadData1, 64'hDEAD_BEEF);
      reset = 1'b1;
      #1;
      clear_model();
      check("async_reset_rd1", ReadData1, 64'h0);
      #1 reset = 1'b0;
      #1;
      check("after_reset_rd1", ReadData1, 64'h0);
      tick();

      // Write/read X7, neighbours stay zero.
      drive(1'b1, 5'd7, 64'h0123_4567_89AB_CDEF, 5'd0, 5'd0);
      tick();
      drive(1'b0, 5'd0, 64'h0, 5'd7, 5'd7);
      check("x7_rd1", ReadData1, 64'h0123_4567_89AB_CDEF);
      check("x7_rd2", ReadData2, 64'h0123_4567_89AB_CDEF);
      drive(1'b0, 5'd0, 64'h0, 5'd6, 5'd8);
      check("x6_zero", ReadData1, 64'h0);
      check("x8_zero", ReadData2, 64'h0);

      // XZR write is discarded and never bypassed.
      drive(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31);
      check("xzr_same_rd1", ReadData1, 64'h0);
      check("xzr_same_rd2", ReadData2, 64'h0);
      tick();
      drive(1'b0, 5'd31, 64'h0, 5'd31, 5'd31);
      check("xzr_next_rd1", ReadData1, 64'h0);
      check("xzr_next_rd2", ReadData2, 64'h0);

      // Bypass on port 1 only, port 2 reads X4 storage.
      drive(1'b1, 5'd4, 64'h44, 5'd0, 5'd0);
      tick();
      drive(1'b1, 5'd3, 64'h11, 5'd0, 5'd0);
      tick();
      drive(1'b1, 5'd3, 64'h22, 5'd3, 5'd4);
      check("bypass_rd1", ReadData1, 64'h22);
      check("bypass_rd2", ReadData2, 64'h44);
      tick();
      drive(1'b0, 5'd0, 64'h0, 5'd3, 5'd3);
      check("bypass_commit", ReadData1, 64'h22);
      drive(1'b1, 5'd9, 64'h99, 5'd9, 5'd9);
      check("bypass_both_rd1", ReadData1, 64'h99);
      check("bypass_both_rd2", ReadData2, 64'h99);
      tick();

      // Disabled write neither bypasses nor commits.
      drive(1'b1, 5'd10, 64'h1010, 5'd0, 5'd0);
      tick();
      drive(1'b0, 5'd10, 64'hAA, 5'd10, 5'd10);
      check("disable_same", ReadData1, 64'h1010);
      tick();
      check("disable_next", ReadData1, 64'h1010);

      // Sweep: each register holds index * 0x0101...
      for (int i = 0; i < 31; i++) begin
         drive(1'b1, 5'(i), 64'(i) * 64'h0101_0101_0101_0101, 5'd31, 5'd31);
         tick();
      end
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 5'd0, 64'h0, 5'(i), 5'(i));
         check($sformatf("sweep_rd1_%0d", i), ReadData1,
               (i == 31) ? 64'h0 : 64'(i) * 64'h0101_0101_0101_0101);
         check($sformatf("sweep_rd2_%0d", i), ReadData2,
               (i == 31) ? 64'h0 : 64'(i) * 64'h0101_0101_0101_0101);
      end

      // Randomized traffic with occasional mid-cycle reset pulses.
      for (int n = 0; n < 400; n++) begin
         logic [4:0]  wr;
         logic [4:0]  r1;
         logic [4:0]  r2;
         logic [63:0] wd;
         wr = 5'($urandom_range(0, 31));
         wd = {$urandom, $urandom};
         r1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
         r2 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
         drive(1'($urandom_range(0, 1)), wr, wd, r1, r2);
         check_ports($sformatf("rand_%0d", n));
         if ($urandom_range(0, 49) == 0) begin
            reset = 1'b1;
            #1;
            clear_model();
            check_ports($sformatf("rand_rst_%0d", n));
            tick();
            check_ports($sformatf("rand_rsthold_%0d", n));
            #2 reset = 1'b0;
            #1;
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_regfile_2r1w

`default_nettype wire

// File: doc/regfile_2r1w.md
REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high; clears all storage immediately on assertion.
REQ-003 SHALL have port RegWrite, input, 1 bit: write enable for the single write port.
REQ-004 SHALL have port WriteRegister, input, 5 bits: destination register index 0-31.
REQ-005 SHALL have port WriteData, input, 64 bits: data for the write port.
REQ-006 SHALL have port ReadRegister1, input, 5 bits: read port 1 index.
REQ-007 SHALL have port ReadRegister2, input, 5 bits: read port 2 index.
REQ-008 SHALL have port ReadData1, output, 64 bits: read port 1 data.
REQ-009 SHALL have port ReadData2, output, 64 bits: read port 2 data.

Function
REQ-010 SHALL hold 31 architectural 64-bit registers X0-X30; index 31 SHALL be XZR with no storage.
REQ-011 SHALL update register WriteRegister to WriteData on a rising clk edge when RegWrite=1, reset=0, and WriteRegister!=31; other registers are unchanged.
REQ-012 SHALL ignore writes when RegWrite=0, or WriteRegister=31 (XZR writes discarded, no side effects).
REQ-013 SHALL drive read ports combinationally: ReadDataN = contents of register ReadRegisterN, zero added cycles.
REQ-014 SHALL return 64'h0 on any read port whose index is 31, regardless of RegWrite/WriteRegister.
REQ-015 SHALL bypass: when RegWrite=1, reset=0, WriteRegister!=31 and WriteRegister==ReadRegisterN, ReadDataN SHALL equal WriteData in the same cycle (write-through, before the edge).
REQ-016 SHALL apply bypass independently per port; both ports may bypass the same write simultaneously.
REQ-017 SHALL allow both read ports to address the same register and return identical data.
REQ-018 SHALL make the written value visible via normal storage path from the cycle after the write edge.
REQ-019 SHALL produce no X on outputs for any 5-bit index; all 32 indices defined.

Reset
REQ-020 SHALL clear X0-X30 to 64'h0 asynchronously on reset assertion, without waiting for clk.
REQ-021 SHALL suppress writes and bypass while reset=1; ReadData1/ReadData2 SHALL read 64'h0 for every index during reset.
REQ-022 SHALL resume normal writes on the first rising clk edge with reset=0; a write coinciding with the reset-deassert edge is ignored only if reset is still sampled 1.
REQ-023 Reset asserted mid-operation SHALL discard any in-flight write of that cycle.

Structure
REQ-024 SHALL place constants NUM_REGS=32, DATA_W=64, IDX_W=5, ZR_IDX=31 in a shared package (regfile_pkg) used by the core.
REQ-025 SHALL use one sub-module, decoder_5_32, producing a one-hot write-enable vector gated by RegWrite; bit 31 is never asserted.
REQ-026 SHALL build storage from per-bit D flip-flops with write-enable muxing, consistent with existing datapath registers; read muxes are 32:1 per port.
REQ-027 SHALL be synthesizable, no latches, timescale 1ns/10ps.

Verification
REQ-028 Reset: assert reset mid-cycle after writing X5=64'hDEAD_BEEF -> ReadData1 (idx 5) = 0 immediately, before next clk edge.
REQ-029 Write/read: write X7=64'h0123_4567_89AB_CDEF, next cycle read idx 7 on both ports -> both = 64'h0123_4567_89AB_CDEF; X6, X8 remain 0.
REQ-030 XZR: RegWrite=1, WriteRegister=31, WriteData=64'hFFFF_FFFF_FFFF_FFFF; read idx 31 same and next cycle -> 64'h0 on both ports.
REQ-031 Bypass: X3 holds 64'h11; RegWrite=1, WriteRegister=3, WriteData=64'h22, ReadRegister1=3, ReadRegister2=4 -> ReadData1=64'h22 pre-edge, ReadData2=X4 contents; after edge X3=64'h22.
REQ-032 Disable: RegWrite=0, WriteRegister=10, WriteData=64'hAA, ReadRegister1=10 -> ReadData1 unchanged (no bypass), X10 unchanged after edge.
REQ-033 Sweep: write X0-X30 with value = index*64'h0101_0101_0101_0101, read all 32 indices on both ports -> expected pattern, idx 31 = 0.
